// File: rtl/fwrisc_prog_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fwrisc_prog_streamer                                          |
// | Brief    : Streams a program image from a byte-wide memory into the      |
// |            UART CSR data register. Each byte is paced by a rising edge   |
// |            of tx_irq or ready. Optional thru-mode set-up write and       |
// |            trailing mod-256 checksum byte.                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

module fwrisc_prog_streamer #(
    parameter int ADDR_W    = 12,
    parameter bit THRU_INIT = 1'b1,
    parameter bit PACE_MODE = 1'b0,
    parameter bit CKSUM_EN  = 1'b0,
    parameter int TIMEOUT_W = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [13:0]       csr_a,
    output logic              csr_we,
    output logic [31:0]       csr_di,
    input  logic              tx_irq,
    input  logic              ready,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [ADDR_W:0]   sent_cnt
);

    // CSR map of the UART as seen by the streamer
    localparam logic [13:0]          C_CSR_DATA = 14'h000;
    localparam logic [13:0]          C_CSR_THRU = 14'h002;

    // Increment constants sized to their counters
    localparam logic [ADDR_W:0]      C_SENT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] C_TMO_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    // The WAIT cycle in which the counter steps onto all-ones is the last one
    localparam logic [TIMEOUT_W-1:0] C_TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CFG   = 3'd1,
        FETCH = 3'd2,
        WRITE = 3'd3,
        WAIT  = 3'd4,
        CKSUM = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_ph;        // second cycle of a two-cycle CSR write
    logic [ADDR_W:0]     r_len;       // byte count latched at start
    logic [ADDR_W:0]     r_sent;      // data bytes written so far
    logic [7:0]          r_acc;       // running mod-256 byte sum
    logic [7:0]          r_byte;      // byte captured in the first WRITE cycle
    logic                r_pend;      // pace event seen while busy writing
    logic                r_ck_sent;   // checksum byte already written
    logic [TIMEOUT_W-1:0] r_tmo;      // WAIT dwell counter
    logic                r_err;       // sticky timeout flag
    logic                r_pace_d;    // pace source delayed one cycle

    logic                w_pace_src;
    logic                w_rise;
    logic                w_evt;
    logic                w_accept;
    logic                w_burst;
    logic                w_tmo_fire;

    // Pace source selection and rising-edge detect against the delayed copy
    assign w_pace_src = PACE_MODE ? ready : tx_irq;
    assign w_rise     = w_pace_src & ~r_pace_d;

    // A pace event in WAIT is either a live edge or one remembered from earlier
    assign w_evt      = r_pend | w_rise;

    // A start is honoured only from IDLE; abort has no effect there
    assign w_accept   = (r_state == IDLE) && start;

    // States that drive a two-cycle CSR write
    assign w_burst    = (r_state == CFG) || (r_state == WRITE) || (r_state == CKSUM);

    // Timeout fires when no event has arrived and the counter would hit all-ones
    assign w_tmo_fire = (r_state == WAIT) && !w_evt && (r_tmo == C_TMO_LAST) && !abort;

    // State register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; abort from any active state overrides everything
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        w_next = DONE;
                    end else begin
                        w_next = THRU_INIT ? CFG : FETCH;
                    end
                end
            end
            CFG: begin
                if (r_ph) begin
                    w_next = FETCH;
                end
            end
            FETCH: begin
                w_next = WRITE;
            end
            WRITE: begin
                if (r_ph) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (w_evt) begin
                    if (r_sent < r_len) begin
                        w_next = FETCH;
                    end else if (CKSUM_EN && !r_ck_sent) begin
                        w_next = CKSUM;
                    end else begin
                        w_next = DONE;
                    end
                end else if (r_tmo == C_TMO_LAST) begin
                    w_next = IDLE;
                end
            end
            CKSUM: begin
                if (r_ph) begin
                    w_next = WAIT;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        if ((r_state != IDLE) && abort) begin
            w_next = IDLE;
        end
    end

    // CSR bus decode from the current state. Read data arrives in the first
    // WRITE cycle, so that cycle forwards it while r_byte captures it; the
    // second cycle replays r_byte, keeping csr_di steady across both cycles.
    always_comb begin
        csr_we = 1'b0;
        csr_a  = 14'h000;
        csr_di = 32'h0000_0000;
        case (r_state)
            CFG: begin
                csr_we = 1'b1;
                csr_a  = C_CSR_THRU;
            end
            WRITE: begin
                csr_we = 1'b1;
                csr_a  = C_CSR_DATA;
                csr_di = {24'h000000, (r_ph ? r_byte : mem_rdata)};
            end
            CKSUM: begin
                csr_we = 1'b1;
                csr_a  = C_CSR_DATA;
                csr_di = {24'h000000, r_acc};
            end
            default: begin
                csr_we = 1'b0;
            end
        endcase
    end

    // Delayed copy of the pace source for edge detection
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_pace_d <= 1'b0;
        end else begin
            r_pace_d <= w_pace_src;
        end
    end

    // Transfer bookkeeping: counters, checksum, pending event, timeout
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_ph      <= 1'b0;
            r_len     <= '0;
            r_sent    <= '0;
            r_acc     <= 8'h00;
            r_byte    <= 8'h00;
            r_pend    <= 1'b0;
            r_ck_sent <= 1'b0;
            r_tmo     <= '0;
            r_err     <= 1'b0;
        end else begin
            // Phase toggles only while staying in a write state
            r_ph <= w_burst && (w_next == r_state);

            if (w_accept) begin
                r_len     <= length;
                r_sent    <= '0;
                r_acc     <= 8'h00;
                r_err     <= 1'b0;
                r_ck_sent <= 1'b0;
            end

            if ((r_state == WRITE) && !r_ph) begin
                r_byte <= mem_rdata;
            end

            // Byte is committed on the second write cycle unless aborted
            if ((r_state == WRITE) && r_ph && !abort) begin
                r_sent <= r_sent + C_SENT_ONE;
                r_acc  <= r_acc + r_byte;
            end

            if (r_state == CKSUM) begin
                r_ck_sent <= 1'b1;
            end

            // WAIT always consumes the pending flag; edges during writes set it
            if (w_accept || (r_state == WAIT)) begin
                r_pend <= 1'b0;
            end else if (((r_state == WRITE) || (r_state == CKSUM)) && w_rise) begin
                r_pend <= 1'b1;
            end

            // Counter sits at zero outside WAIT, so every WAIT entry starts fresh
            if (r_state == WAIT) begin
                r_tmo <= r_tmo + C_TMO_ONE;
            end else begin
                r_tmo <= '0;
            end

            if (w_tmo_fire) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_addr    = r_sent[ADDR_W-1:0];
    assign sent_cnt    = r_sent;
    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign timeout_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fwrisc_prog_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fwrisc_prog_streamer                                       |
// | Brief    : Directed self-checking bench for fwrisc_prog_streamer.        |
// |            Instance A: thru-init, tx_irq pacing, no checksum.            |
// |            Instance B: thru-init, ready pacing, checksum, 4-bit timeout. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

module tb_fwrisc_prog_streamer;

    localparam int AW = 4;

    typedef struct packed {
        logic [13:0] a;
        logic [31:0] d;
        logic [7:0]  n;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A ----------------
    logic          a_start = 1'b0;
    logic          a_abort = 1'b0;
    logic [AW:0]   a_len   = '0;
    logic [AW-1:0] a_mem_addr;
    logic [7:0]    a_rdata;
    logic [13:0]   a_csr_a;
    logic          a_csr_we;
    logic [31:0]   a_csr_di;
    logic          a_irq_auto = 1'b0;
    logic          a_busy, a_done, a_err;
    logic [AW:0]   a_sent;
    logic [7:0]    a_mem [0:15];

    fwrisc_prog_streamer #(
        .ADDR_W(AW), .THRU_INIT(1'b1), .PACE_MODE(1'b0), .CKSUM_EN(1'b0), .TIMEOUT_W(16)
    ) u_dut_a (
        .sys_clk(clk), .sys_rst(rst), .start(a_start), .abort(a_abort), .length(a_len),
        .mem_addr(a_mem_addr), .mem_rdata(a_rdata), .csr_a(a_csr_a), .csr_we(a_csr_we),
        .csr_di(a_csr_di), .tx_irq(a_irq_auto), .ready(1'b0), .busy(a_busy), .done(a_done),
        .timeout_err(a_err), .sent_cnt(a_sent)
    );

    always @(posedge clk) a_rdata <= a_mem[a_mem_addr];

    // ---------------- instance B ----------------
    logic          b_start = 1'b0;
    logic          b_abort = 1'b0;
    logic [AW:0]   b_len   = '0;
    logic [AW-1:0] b_mem_addr;
    logic [7:0]    b_rdata;
    logic [13:0]   b_csr_a;
    logic          b_csr_we;
    logic [31:0]   b_csr_di;
    logic          b_ready_auto = 1'b0;
    logic          b_ready_man  = 1'b0;
    logic          b_ready;
    logic          b_auto = 1'b1;
    logic          b_busy, b_done, b_err;
    logic [AW:0]   b_sent;
    logic [7:0]    b_mem [0:15];

    assign b_ready = b_ready_auto | b_ready_man;

    fwrisc_prog_streamer #(
        .ADDR_W(AW), .THRU_INIT(1'b1), .PACE_MODE(1'b1), .CKSUM_EN(1'b1), .TIMEOUT_W(4)
    ) u_dut_b (
        .sys_clk(clk), .sys_rst(rst), .start(b_start), .abort(b_abort), .length(b_len),
        .mem_addr(b_mem_addr), .mem_rdata(b_rdata), .csr_a(b_csr_a), .csr_we(b_csr_we),
        .csr_di(b_csr_di), .tx_irq(1'b0), .ready(b_ready), .busy(b_busy), .done(b_done),
        .timeout_err(b_err), .sent_cnt(b_sent)
    );

    always @(posedge clk) b_rdata <= b_mem[b_mem_addr];

    // ---------------- write monitors and pace responders ----------------
    wr_t  a_log[$];
    wr_t  a_run;
    logic a_we_q = 1'b0;
    int   a_cd = 0, a_done_cnt = 0, a_hold_err = 0;

    always @(negedge clk) begin
        a_irq_auto = 1'b0;
        if (a_cd != 0) begin
            a_cd = a_cd - 1;
            if (a_cd == 0) a_irq_auto = 1'b1;
        end
        if (a_csr_we === 1'b1) begin
            if (!a_we_q) begin
                a_run.a = a_csr_a; a_run.d = a_csr_di; a_run.n = 8'd1;
            end else begin
                a_run.n = a_run.n + 8'd1;
                if ((a_csr_di !== a_run.d) || (a_csr_a !== a_run.a)) a_hold_err++;
            end
        end else if (a_we_q) begin
            a_log.push_back(a_run);
            if (a_run.a == 14'h0) a_cd = 20;
        end
        a_we_q = (a_csr_we === 1'b1);
        if (a_done === 1'b1) a_done_cnt++;
    end

    wr_t  b_log[$];
    wr_t  b_run;
    logic b_we_q = 1'b0;
    int   b_cd = 0, b_done_cnt = 0, b_hold_err = 0;

    always @(negedge clk) begin
        b_ready_auto = 1'b0;
        if (b_cd != 0) begin
            b_cd = b_cd - 1;
            if (b_cd == 0) b_ready_auto = 1'b1;
        end
        if (b_csr_we === 1'b1) begin
            if (!b_we_q) begin
                b_run.a = b_csr_a; b_run.d = b_csr_di; b_run.n = 8'd1;
            end else begin
                b_run.n = b_run.n + 8'd1;
                if ((b_csr_di !== b_run.d) || (b_csr_a !== b_run.a)) b_hold_err++;
            end
        end else if (b_we_q) begin
            b_log.push_back(b_run);
            if ((b_run.a == 14'h0) && b_auto) b_cd = 5;
        end
        b_we_q = (b_csr_we === 1'b1);
        if (b_done === 1'b1) b_done_cnt++;
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_a_busy got %b exp 0", a_busy); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_a_done got %b exp 0", a_done); end
        checks++; if (a_csr_we !== 1'b0) begin errors++; $display("FAIL reset_a_we got %b exp 0", a_csr_we); end
        checks++; if (a_csr_a !== 14'h0) begin errors++; $display("FAIL reset_a_csr_a got %h exp 0", a_csr_a); end
        checks++; if (a_csr_di !== 32'h0) begin errors++; $display("FAIL reset_a_csr_di got %h exp 0", a_csr_di); end
        checks++; if (a_mem_addr !== 4'h0) begin errors++; $display("FAIL reset_a_addr got %h exp 0", a_mem_addr); end
        checks++; if (a_sent !== 5'd0) begin errors++; $display("FAIL reset_a_sent got %0d exp 0", a_sent); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_a_tmo got %b exp 0", a_err); end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_b_busy got %b exp 0", b_busy); end
        checks++; if (b_csr_we !== 1'b0) begin errors++; $display("FAIL reset_b_we got %b exp 0", b_csr_we); end
    endtask

    task automatic test_thru_stream();
        int n0, d0, h0, k;
        logic [13:0] ea [0:3];
        logic [31:0] ed [0:3];
        wr_t e;
        ea[0] = 14'h002; ea[1] = 14'h0; ea[2] = 14'h0; ea[3] = 14'h0;
        ed[0] = 32'h0;   ed[1] = 32'h13; ed[2] = 32'h05; ed[3] = 32'h67;
        a_mem[0] = 8'h13; a_mem[1] = 8'h05; a_mem[2] = 8'h67;
        n0 = a_log.size(); d0 = a_done_cnt; h0 = a_hold_err;
        @(negedge clk); a_len = 5'd3; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        k = 0; while (a_busy && k < 2000) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL thru_finish busy got %b exp 0", a_busy); end
        checks++; if (a_log.size() != n0 + 4) begin errors++; $display("FAIL thru_nwrites got %0d exp 4", a_log.size() - n0); end
        for (int i = 0; i < 4; i++) begin
            e = (n0 + i < a_log.size()) ? a_log[n0 + i] : '0;
            checks++;
            if (e !== {ea[i], ed[i], 8'd2}) begin
                errors++; $display("FAIL thru_write%0d got a=%h d=%h n=%0d exp a=%h d=%h n=2", i, e.a, e.d, e.n, ea[i], ed[i]);
            end
        end
        checks++; if (a_sent !== 5'd3) begin errors++; $display("FAIL thru_sent got %0d exp 3", a_sent); end
        checks++; if (a_done_cnt - d0 != 1) begin errors++; $display("FAIL thru_done got %0d exp 1", a_done_cnt - d0); end
        checks++; if (a_hold_err != h0) begin errors++; $display("FAIL thru_di_hold got %0d exp %0d", a_hold_err, h0); end
    endtask

    task automatic test_zero_length();
        int n0;
        n0 = a_log.size();
        @(negedge clk); a_len = 5'd0; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL zero_done_pulse got %b exp 1", a_done); end
        @(negedge clk);
        checks++; if ({a_done, a_busy} !== 2'b00) begin errors++; $display("FAIL zero_after got done,busy=%b exp 00", {a_done, a_busy}); end
        repeat (4) @(negedge clk);
        checks++; if (a_log.size() != n0) begin errors++; $display("FAIL zero_nwrites got %0d exp 0", a_log.size() - n0); end
    endtask

    task automatic test_full_length();
        int n0, d0, k;
        wr_t e;
        for (int i = 0; i < 16; i++) a_mem[i] = 8'((i * 17 + 1) & 255);
        n0 = a_log.size(); d0 = a_done_cnt;
        @(negedge clk); a_len = 5'd16; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        k = 0; while (a_busy && k < 3000) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL full_finish busy got %b exp 0", a_busy); end
        checks++; if (a_log.size() != n0 + 17) begin errors++; $display("FAIL full_nwrites got %0d exp 17", a_log.size() - n0); end
        for (int i = 0; i < 16; i++) begin
            e = (n0 + 1 + i < a_log.size()) ? a_log[n0 + 1 + i] : '0;
            checks++;
            if (e !== {14'h0, 24'h0, a_mem[i], 8'd2}) begin
                errors++; $display("FAIL full_byte%0d got a=%h d=%h n=%0d exp a=0 d=%h n=2", i, e.a, e.d, e.n, a_mem[i]);
            end
        end
        checks++; if (a_sent !== 5'd16) begin errors++; $display("FAIL full_sent got %0d exp 16", a_sent); end
        checks++; if (a_done_cnt - d0 != 1) begin errors++; $display("FAIL full_done got %0d exp 1", a_done_cnt - d0); end
    endtask

    task automatic test_abort();
        int n0, n1, d0, k;
        wr_t e;
        a_mem[0] = 8'h11; a_mem[1] = 8'h22; a_mem[2] = 8'h33; a_mem[3] = 8'h44;
        n0 = a_log.size(); d0 = a_done_cnt;
        @(negedge clk); a_len = 5'd4; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        k = 0; while ((a_log.size() < n0 + 3) && k < 2000) begin @(negedge clk); k++; end
        a_abort = 1'b1;
        @(negedge clk); a_abort = 1'b0;
        checks++; if ({a_busy, a_csr_we} !== 2'b00) begin errors++; $display("FAIL abort_idle got busy,we=%b exp 00", {a_busy, a_csr_we}); end
        repeat (60) @(negedge clk);
        checks++; if (a_log.size() != n0 + 3) begin errors++; $display("FAIL abort_nwrites got %0d exp 3", a_log.size() - n0); end
        checks++; if (a_sent !== 5'd2) begin errors++; $display("FAIL abort_sent got %0d exp 2", a_sent); end
        checks++; if (a_done_cnt != d0) begin errors++; $display("FAIL abort_done got %0d exp 0", a_done_cnt - d0); end
        // start and abort together while idle: start must win
        n1 = a_log.size();
        a_len = 5'd4; a_start = 1'b1; a_abort = 1'b1;
        @(negedge clk); a_start = 1'b0; a_abort = 1'b0;
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL start_wins busy got %b exp 1", a_busy); end
        k = 0; while (a_busy && k < 2000) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
        checks++; if (a_log.size() != n1 + 5) begin errors++; $display("FAIL restart_nwrites got %0d exp 5", a_log.size() - n1); end
        e = (n1 + 1 < a_log.size()) ? a_log[n1 + 1] : '0;
        checks++; if (e.d !== 32'h11) begin errors++; $display("FAIL restart_first got %h exp 11", e.d); end
        checks++; if (a_sent !== 5'd4) begin errors++; $display("FAIL restart_sent got %0d exp 4", a_sent); end
        checks++; if (a_done_cnt - d0 != 1) begin errors++; $display("FAIL restart_done got %0d exp 1", a_done_cnt - d0); end
    endtask

    task automatic test_cksum();
        int n0, d0, k;
        logic [13:0] ea [0:3];
        logic [31:0] ed [0:3];
        wr_t e;
        ea[0] = 14'h002; ea[1] = 14'h0; ea[2] = 14'h0; ea[3] = 14'h0;
        ed[0] = 32'h0;   ed[1] = 32'hF0; ed[2] = 32'h20; ed[3] = 32'h10;
        b_mem[0] = 8'hF0; b_mem[1] = 8'h20;
        b_auto = 1'b1;
        n0 = b_log.size(); d0 = b_done_cnt;
        @(negedge clk); b_len = 5'd2; b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        k = 0; while (b_busy && k < 1000) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
        checks++; if (b_log.size() != n0 + 4) begin errors++; $display("FAIL cksum_nwrites got %0d exp 4", b_log.size() - n0); end
        for (int i = 0; i < 4; i++) begin
            e = (n0 + i < b_log.size()) ? b_log[n0 + i] : '0;
            checks++;
            if (e !== {ea[i], ed[i], 8'd2}) begin
                errors++; $display("FAIL cksum_write%0d got a=%h d=%h n=%0d exp a=%h d=%h n=2", i, e.a, e.d, e.n, ea[i], ed[i]);
            end
        end
        checks++; if (b_sent !== 5'd2) begin errors++; $display("FAIL cksum_sent got %0d exp 2", b_sent); end
        checks++; if (b_done_cnt - d0 != 1) begin errors++; $display("FAIL cksum_done got %0d exp 1", b_done_cnt - d0); end
        checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL cksum_tmo got %b exp 0", b_err); end
    endtask

    task automatic test_timeout();
        int d0, k;
        b_auto = 1'b0;
        b_mem[0] = 8'h5A;
        d0 = b_done_cnt;
        @(negedge clk); b_len = 5'd1; b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        k = 0; while (!((b_csr_we === 1'b1) && (b_csr_a === 14'h0)) && k < 200) begin @(negedge clk); k++; end
        k = 0; while ((b_csr_we === 1'b1) && k < 10) begin @(negedge clk); k++; end
        // now in the first WAIT cycle
        repeat (14) @(negedge clk);
        checks++; if ({b_err, b_busy} !== 2'b01) begin errors++; $display("FAIL tmo_early got err,busy=%b exp 01", {b_err, b_busy}); end
        @(negedge clk);
        checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL tmo_flag got %b exp 1", b_err); end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL tmo_busy got %b exp 0", b_busy); end
        repeat (3) @(negedge clk);
        checks++; if (b_done_cnt != d0) begin errors++; $display("FAIL tmo_done got %0d exp 0", b_done_cnt - d0); end
    endtask

    task automatic test_ready_pace();
        int n0, d0, k;
        wr_t e;
        b_auto = 1'b0;
        b_mem[0] = 8'h31; b_mem[1] = 8'h42;
        n0 = b_log.size(); d0 = b_done_cnt;
        @(negedge clk); b_len = 5'd2; b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL pace_err_clear got %b exp 0", b_err); end
        k = 0; while (!((b_csr_we === 1'b1) && (b_csr_a === 14'h0)) && k < 200) begin @(negedge clk); k++; end
        @(negedge clk);
        b_ready_man = 1'b1;             // rises in the second WRITE cycle
        @(negedge clk);
        checks++; if ({b_busy, b_csr_we} !== 2'b10) begin errors++; $display("FAIL pace_wait got busy,we=%b exp 10", {b_busy, b_csr_we}); end
        @(negedge clk);
        checks++; if ({b_csr_we, b_mem_addr} !== {1'b0, 4'd1}) begin errors++; $display("FAIL pace_fetch got we=%b addr=%0d exp we=0 addr=1", b_csr_we, b_mem_addr); end
        @(negedge clk);
        checks++; if ({b_csr_we, b_csr_di} !== {1'b1, 32'h42}) begin errors++; $display("FAIL pace_write got we=%b di=%h exp we=1 di=42", b_csr_we, b_csr_di); end
        b_ready_man = 1'b0;
        b_auto = 1'b1;
        k = 0; while (b_busy && k < 1000) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
        e = (n0 + 3 < b_log.size()) ? b_log[n0 + 3] : '0;
        checks++; if (e.d !== 32'h73) begin errors++; $display("FAIL pace_cksum got %h exp 73", e.d); end
        checks++; if (b_sent !== 5'd2) begin errors++; $display("FAIL pace_sent got %0d exp 2", b_sent); end
        checks++; if (b_done_cnt - d0 != 1) begin errors++; $display("FAIL pace_done got %0d exp 1", b_done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        int d0, k;
        a_mem[0] = 8'h13; a_mem[1] = 8'h05; a_mem[2] = 8'h67;
        @(negedge clk); a_len = 5'd3; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        k = 0; while ((a_csr_we !== 1'b1) && k < 50) begin @(negedge clk); k++; end
        d0 = a_done_cnt;
        #2 rst = 1'b1;
        #1;
        checks++; if ({a_csr_we, a_busy} !== 2'b00) begin errors++; $display("FAIL rstmid_async got we,busy=%b exp 00", {a_csr_we, a_busy}); end
        checks++; if (a_sent !== 5'd0) begin errors++; $display("FAIL rstmid_sent got %0d exp 0", a_sent); end
        @(negedge clk); rst = 1'b0;
        repeat (80) @(negedge clk);
        checks++; if (a_done_cnt != d0) begin errors++; $display("FAIL rstmid_done got %0d exp 0", a_done_cnt - d0); end
        checks++; if ({a_busy, a_csr_we} !== 2'b00) begin errors++; $display("FAIL rstmid_idle got busy,we=%b exp 00", {a_busy, a_csr_we}); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_thru_stream();
        test_zero_length();
        test_full_length();
        test_abort();
        test_cksum();
        test_timeout();
        test_ready_pace();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fwrisc_prog_streamer.md
FWRISC_PROG_STREAMER -- requirements
Module: fwrisc_prog_streamer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- ADDR_W, 12, program memory address width; depth 2^ADDR_W bytes.
- THRU_INIT, 1, issue a thru-mode register write before the first data byte.
- PACE_MODE, 0, selects the pacing event: 0 = rising tx_irq, 1 = rising ready.
- CKSUM_EN, 0, append one checksum byte after the data.
- TIMEOUT_W, 16, width of the wait-for-pace-event timeout counter.

REQ-002 Ports, one per line (name, direction, width, meaning):
- sys_clk  in  1  single clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle start pulse.
- abort  in  1  one-cycle abort pulse.
- length  in  ADDR_W+1  byte count, legal range 0..2^ADDR_W; sampled on start.
- mem_addr  out  ADDR_W  program memory read address.
- mem_rdata  in  8  read data; valid exactly one cycle after mem_addr.
- csr_a  out  14  UART CSR address.
- csr_we  out  1  UART CSR write enable.
- csr_di  out  32  UART CSR write data.
- tx_irq  in  1  UART transmit-done.
- ready  in  1  receiver-ready (program_receiving).
- busy  out  1  high while a transfer is active.
- done  out  1  one-cycle completion pulse.
- timeout_err  out  1  sticky error flag; cleared by start.
- sent_cnt  out  ADDR_W+1  number of data bytes written so far.

Function
REQ-003 FSM states SHALL be: IDLE, CFG, FETCH, WRITE, WAIT, CKSUM, DONE.
REQ-004 In IDLE, start with length>0 SHALL go to CFG if THRU_INIT=1, else to FETCH.
- The same start SHALL clear timeout_err, sent_cnt and the checksum accumulator.
REQ-005 In IDLE, start with length==0 SHALL go directly to DONE and issue no CSR writes.
REQ-006 start while busy SHALL be ignored.
REQ-007 CFG: csr_a=14'h002, csr_di=0, csr_we=1 for exactly 2 cycles, then FETCH.
REQ-008 FETCH (1 cycle): mem_addr=sent_cnt[ADDR_W-1:0], then WRITE.
REQ-009 WRITE: csr_a=0, csr_di={24'h0,mem_rdata}, csr_we=1 for exactly 2 cycles.
- csr_di SHALL be registered on the first WRITE cycle and held for both cycles.
- On the second WRITE cycle: sent_cnt SHALL increment by 1 and the byte SHALL be added to the accumulator mod 256.
REQ-010 After WRITE the FSM SHALL go to WAIT.
REQ-011 Pace event = rising edge of the input selected by PACE_MODE, detected with a one-cycle-delayed register.
- An event occurring in WRITE or CKSUM SHALL set a pending flag; WAIT SHALL consume the flag as an event.
REQ-012 WAIT on event: sent_cnt<length -> FETCH.
- sent_cnt==length with CKSUM_EN=1 and the checksum not yet sent -> CKSUM.
- Otherwise -> DONE.
REQ-013 CKSUM: csr_di={24'h0,accumulator}, csr_a=0, csr_we=1 for 2 cycles, then WAIT; sent_cnt SHALL NOT increment.
REQ-014 WAIT timeout counter: cleared on WAIT entry, increments each WAIT cycle.
- On reaching 2^TIMEOUT_W-1: set timeout_err, go to IDLE, no done pulse.
REQ-015 DONE: done=1 for 1 cycle, then IDLE.
REQ-016 busy SHALL be 1 in all states except IDLE.
REQ-017 abort in any non-IDLE state: csr_we=0 on the next cycle, go to IDLE, no done pulse, sent_cnt held.
REQ-018 abort and start in the same cycle while in IDLE: start wins.
REQ-019 length==2^ADDR_W SHALL send every address 0..2^ADDR_W-1; mem_addr SHALL NOT wrap before completion.
REQ-020 Outside CFG/WRITE/CKSUM: csr_we=0, csr_a=0, csr_di=0.

Reset
REQ-021 sys_rst high SHALL asynchronously force:
- state=IDLE
- csr_we=0, csr_a=0, csr_di=0, mem_addr=0
- busy=0, done=0, timeout_err=0, sent_cnt=0
- accumulator, pending flag and timeout counter to 0.
REQ-022 Reset asserted mid-transfer SHALL terminate csr_we within the reset-assertion time, with no done pulse after release.

Verification
REQ-023 Scenario, THRU_INIT=1, length=3, mem={0x13,0x05,0x67}, tx_irq pulses 20 cycles after each write:
- -> CSR writes in order: (0x002,0x0), (0x000,0x13), (0x000,0x05), (0x000,0x67).
- -> each write has csr_we high exactly 2 cycles; done pulses once; sent_cnt=3.
REQ-024 Scenario, CKSUM_EN=1, length=2, mem={0xF0,0x20} -> fourth write carries 0x10; sent_cnt=2.
REQ-025 Scenario, start with length=0 -> done pulses the cycle after IDLE exit; zero CSR writes.
REQ-026 Scenario, TIMEOUT_W=4, no pace events -> timeout_err=1 exactly 15 WAIT cycles after the first data write; busy=0; no done pulse.
REQ-027 Scenario, PACE_MODE=1, ready rises during the second WRITE cycle -> the next FETCH follows WAIT entry by one cycle.
REQ-028 Scenario, abort after the 2nd of 4 bytes -> no further writes, sent_cnt=2; a new start then resends from address 0.
